fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one outstanding word fetch at a time,
// buffers returned words with their PCs in a small queue, and flushes on
// redirect. Stale responses to requests issued before a redirect are dropped.
module fetch_unit #(
  parameter int             XLEN     = 32,
  parameter int             DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_addr,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr_data,
  output logic [XLEN-1:0]          instr_pc,
  output logic [XLEN-1:0]          instr_pc_plus4,
  output logic                     misalign_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] req_pc_reg;
  logic            outstanding_reg;
  logic            drop_reg;
  logic            misalign_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic [31:0]     word_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic fire;
  logic resp;
  logic push;
  logic pop;

  // Only request when no response is pending and a slot is guaranteed free,
  // so every accepted response always has room in the queue.
  assign imem_req  = !rst && !redirect_valid && !outstanding_reg &&
                     (count_reg < CW'(DEPTH));
  assign imem_addr = fetch_pc_reg;

  assign fire = imem_req && imem_gnt;
  assign resp = imem_rvalid && outstanding_reg;
  assign push = resp && !drop_reg && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid    = (count_reg != '0);
  assign instr_data     = word_mem[rd_ptr_reg];
  assign instr_pc       = pc_mem[rd_ptr_reg];
  assign instr_pc_plus4 = pc_mem[rd_ptr_reg] + XLEN'(4);
  assign misalign_err   = misalign_reg;
  assign count          = count_reg;

  // Fetch control, request tracking and queue pointers; reset beats redirect,
  // and redirect beats any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      req_pc_reg      <= '0;
      outstanding_reg <= 1'b0;
      drop_reg        <= 1'b0;
      misalign_reg    <= 1'b0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      misalign_reg <= redirect_valid && (redirect_addr[1:0] != 2'b00);
      if (redirect_valid) begin
        fetch_pc_reg <= {redirect_addr[XLEN-1:2], 2'b00};
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= '0;
        count_reg    <= '0;
        if (outstanding_reg) begin
          if (imem_rvalid) begin
            // Response lands with the redirect: consume it here and now.
            outstanding_reg <= 1'b0;
            drop_reg        <= 1'b0;
          end else begin
            // Response still in flight: remember to throw it away.
            drop_reg <= 1'b1;
          end
        end
      end else begin
        if (fire) begin
          outstanding_reg <= 1'b1;
          req_pc_reg      <= fetch_pc_reg;
          fetch_pc_reg    <= fetch_pc_reg + XLEN'(4);
        end
        if (resp) begin
          outstanding_reg <= 1'b0;
          drop_reg        <= 1'b0;
        end
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Queue storage write port; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]   <= req_pc_reg;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_fetch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0]     word;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            imem_gnt = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_addr = '0;
  logic            instr_ready = 1'b0;

  logic            imem_req, instr_valid, misalign_err;
  logic [XLEN-1:0] imem_addr, instr_pc, instr_pc_plus4;
  logic [31:0]     instr_data;
  logic [CW-1:0]   count;

  logic            w_req, w_valid, w_mis;
  logic [XLEN-1:0] w_addr_o, w_pc_o, w_p4_o;
  logic [31:0]     w_data_o;
  logic [CW-1:0]   w_count_o;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
    .misalign_err(misalign_err), .count(count)
  );

  // Second instance shares all inputs; it only differs in its reset PC.
  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr_o),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_valid(w_valid), .instr_ready(instr_ready), .instr_data(w_data_o),
    .instr_pc(w_pc_o), .instr_pc_plus4(w_p4_o),
    .misalign_err(w_mis), .count(w_count_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  entry_t          mq[$];
  logic [XLEN-1:0] m_fpc = '0;
  logic [XLEN-1:0] m_ppc = '0;
  bit              m_pend = 0, m_stale = 0, m_mis = 0, m_init = 0;

  // Memory responder state
  bit mem_pend = 0;
  int mem_cnt  = 0;

  // Stimulus knobs
  bit              k_rst = 1, k_redir = 0;
  int              k_ready = 0, k_gnt = 0, k_delay = 0;
  int              k_redir_pct = 0, k_spur_pct = 0, k_rst_pct = 0;
  logic [XLEN-1:0] k_raddr = '0;

  // Samples taken one step after the falling edge
  logic            s_req, s_valid, s_mis;
  logic [XLEN-1:0] s_addr, s_pc, s_p4;
  logic [31:0]     s_data;
  logic [CW-1:0]   s_count;
  logic [XLEN-1:0] w_addr, w_count;
  logic [XLEN-1:0] pop_pc[$], pop_p4[$], w_pop_pc[$], w_pop_p4[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cycle();
    logic [31:0]     r;
    logic [XLEN-1:0] e_p4;
    bit              e_req, do_pop, do_req;
    entry_t          e;
    @(negedge clk);
    rst = k_rst || ((k_rst_pct > 0) && ($urandom_range(0, 999) < k_rst_pct));
    imem_rvalid = 1'b0;
    if (mem_pend && mem_cnt == 0) imem_rvalid = 1'b1;
    else if (!mem_pend && ($urandom_range(0, 99) < k_spur_pct)) imem_rvalid = 1'b1;
    imem_rdata = $urandom;
    imem_gnt = !mem_pend && (k_gnt == 1 || (k_gnt == 2 && $urandom_range(0, 3) != 0));
    redirect_valid = k_redir || ($urandom_range(0, 99) < k_redir_pct);
    r = $urandom;
    if (k_redir) redirect_addr = k_raddr;
    else if ($urandom_range(0, 9) == 0) redirect_addr = 32'hFFFF_FFF8 | (r & 32'h3);
    else if ($urandom_range(0, 3) == 0) redirect_addr = r;
    else redirect_addr = r & 32'hFFFF_FFFC;
    instr_ready = (k_ready == 2) ? 1'($urandom_range(0, 1)) : (k_ready != 0);
    k_redir = 0;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid; s_pc = instr_pc;
    s_p4 = instr_pc_plus4; s_data = instr_data; s_count = count; s_mis = misalign_err;
    w_addr = w_addr_o; w_count = XLEN'(w_count_o);
    e_req = !rst && !redirect_valid && !m_pend && (mq.size() < DEPTH);
    if (m_init) begin
      chk("imem_req", 64'(s_req), 64'(e_req));
      chk("imem_addr", 64'(s_addr), 64'(m_fpc));
      chk("count", 64'(s_count), 64'(mq.size()));
      chk("instr_valid", 64'(s_valid), 64'(mq.size() != 0));
      chk("misalign_err", 64'(s_mis), 64'(m_mis));
      if (mq.size() != 0) begin
        e_p4 = mq[0].pc + 32'd4;
        chk("instr_data", 64'(s_data), 64'(mq[0].word));
        chk("instr_pc", 64'(s_pc), 64'(mq[0].pc));
        chk("instr_pc_plus4", 64'(s_p4), 64'(e_p4));
      end
    end
    if (!rst && !redirect_valid && instr_ready) begin
      if (s_valid) begin
        pop_pc.push_back(s_pc); pop_p4.push_back(s_p4);
        $display("pop pc=%h data=%h count=%0d", s_pc, s_data, s_count);
      end
      if (w_valid) begin
        w_pop_pc.push_back(w_pc_o); w_pop_p4.push_back(w_p4_o);
        $display("pop(alt) pc=%h data=%h count=%0d", w_pc_o, w_data_o, w_count);
      end
    end
    @(posedge clk);
    // Model update from the spec's rules
    if (rst) begin
      m_fpc = 32'h0; m_pend = 0; m_stale = 0; m_mis = 0; mq.delete(); m_init = 1;
    end else begin
      m_mis = redirect_valid && (redirect_addr[1:0] != 2'b00);
      if (redirect_valid) begin
        mq.delete();
        m_fpc = {redirect_addr[XLEN-1:2], 2'b00};
        if (m_pend) begin
          if (imem_rvalid) begin m_pend = 0; m_stale = 0; end
          else m_stale = 1;
        end
      end else begin
        do_pop = (mq.size() != 0) && instr_ready;
        do_req = (mq.size() < DEPTH) && !m_pend;
        if (do_pop) void'(mq.pop_front());
        if (imem_rvalid && m_pend) begin
          if (!m_stale) begin
            e.word = imem_rdata; e.pc = m_ppc; mq.push_back(e);
          end
          m_stale = 0; m_pend = 0;
        end else if (do_req && imem_gnt) begin
          m_pend = 1; m_ppc = m_fpc; m_fpc = m_fpc + 32'd4;
        end
      end
    end
    // Memory responder update
    if (mem_pend) begin
      if (mem_cnt == 0) mem_pend = 0;
      else mem_cnt--;
    end else if (imem_gnt && e_req) begin
      mem_pend = 1;
      mem_cnt = (k_delay < 0) ? int'($urandom_range(0, 4)) : k_delay;
    end
  endtask

  initial begin
    logic [XLEN-1:0] exp_pc[3];
    logic [XLEN-1:0] exp_p4[3];
    bit saw_nonzero;
    int n;
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    exp_p4[0] = 32'h4; exp_p4[1] = 32'h8; exp_p4[2] = 32'hC;

    // Reset state
    k_rst = 1;
    repeat (2) cycle();
    chk("rst_count", 64'(s_count), 64'd0);
    chk("rst_valid", 64'(s_valid), 64'd0);
    chk("rst_req", 64'(s_req), 64'd0);
    chk("rst_mis", 64'(s_mis), 64'd0);
    chk("rst_addr", 64'(s_addr), 64'h0);
    chk("rst_addr_wrap", 64'(w_addr), 64'hFFFF_FFFC);

    // Sequential fetch with immediate responses
    k_rst = 0; k_gnt = 1; k_delay = 0; k_ready = 1;
    pop_pc.delete(); pop_p4.delete(); w_pop_pc.delete(); w_pop_p4.delete();
    cycle();
    chk("first_addr", 64'(s_addr), 64'h0);
    chk("first_req", 64'(s_req), 64'd1);
    chk("wrap_first_addr", 64'(w_addr), 64'hFFFF_FFFC);
    cycle();
    chk("wrap_next_addr", 64'(w_addr), 64'h0);
    repeat (8) cycle();
    chk("seq_pop_count", 64'(pop_pc.size() >= 3), 64'd1);
    if (pop_pc.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("seq_pc", 64'(pop_pc[i]), 64'(exp_pc[i]));
        chk("seq_pc_plus4", 64'(pop_p4[i]), 64'(exp_p4[i]));
      end
    end
    chk("wrap_pop_count", 64'(w_pop_pc.size() >= 1), 64'd1);
    if (w_pop_pc.size() >= 1) begin
      chk("wrap_pc", 64'(w_pop_pc[0]), 64'hFFFF_FFFC);
      chk("wrap_pc_plus4", 64'(w_pop_p4[0]), 64'h0);
    end

    // Fill the queue, then free one slot
    k_rst = 1; cycle();
    k_rst = 0; k_ready = 0; k_gnt = 1; k_delay = 0;
    repeat (12) cycle();
    chk("full_count", 64'(s_count), 64'd4);
    chk("full_req", 64'(s_req), 64'd0);
    cycle();
    chk("full_req_hold", 64'(s_req), 64'd0);
    k_ready = 1; cycle();
    k_ready = 0; cycle();
    chk("after_pop_count", 64'(s_count), 64'd3);
    chk("after_pop_req", 64'(s_req), 64'd1);
    cycle();
    cycle();
    chk("refill_count", 64'(s_count), 64'd4);
    chk("refill_req", 64'(s_req), 64'd0);

    // Redirect while a request is in flight
    k_rst = 1; cycle();
    k_rst = 0; k_gnt = 0; k_ready = 1;
    k_redir = 1; k_raddr = 32'h10; cycle();
    k_gnt = 1; k_delay = 3; cycle();
    chk("grant_addr", 64'(s_addr), 64'h10);
    chk("grant_req", 64'(s_req), 64'd1);
    k_gnt = 0; k_redir = 1; k_raddr = 32'h200; cycle();
    k_gnt = 1; k_delay = 0;
    cycle();
    chk("redir_addr", 64'(s_addr), 64'h200);
    chk("redir_req_blocked", 64'(s_req), 64'd0);
    saw_nonzero = 0; n = 0;
    while (!s_valid && n < 20) begin
      if (s_count != 0) saw_nonzero = 1;
      cycle();
      n++;
    end
    chk("redir_empty_until_return", 64'(saw_nonzero), 64'd0);
    chk("redir_valid", 64'(s_valid), 64'd1);
    chk("redir_pc", 64'(s_pc), 64'h200);

    // Misaligned redirect
    k_rst = 1; cycle();
    k_rst = 0; k_gnt = 0; k_redir = 1; k_raddr = 32'h102; cycle();
    chk("mis_same_cycle", 64'(s_mis), 64'd0);
    cycle();
    chk("mis_pulse", 64'(s_mis), 64'd1);
    chk("mis_addr", 64'(s_addr), 64'h100);
    cycle();
    chk("mis_clear", 64'(s_mis), 64'd0);

    // Reset while a request is outstanding
    k_rst = 1; cycle();
    k_rst = 0; k_gnt = 1; k_delay = 1; cycle();
    k_gnt = 0; k_rst = 1; cycle();
    k_rst = 0; cycle();
    cycle();
    chk("abort_count", 64'(s_count), 64'd0);
    chk("abort_valid", 64'(s_valid), 64'd0);
    chk("abort_addr", 64'(s_addr), 64'h0);

    // Randomized traffic
    k_gnt = 2; k_delay = -1; k_ready = 2;
    k_redir_pct = 8; k_spur_pct = 10; k_rst_pct = 5;
    repeat (4000) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
